interleaved_stream_splitter: RTL and testbench

// - Splits one valid-ready stream into two lanes in strict alternation: accepted word 0 goes to lane0, word 1 to lane1, and so on.
// - Feeds a pair of half-rate (2t) consumers, e.g. two sync_2t_fifo banks or two BRAM write ports, from a 1t producer.
// - Each lane has a 2-entry skid buffer, so backpressure on one lane stalls the input only when that lane is next and full.

---
 rtl/interleaved_stream_splitter.sv | 163 ++++++++++++++++
 tb/tb_interleaved_stream_splitter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interleaved_stream_splitter.sv
//==============================================================================
// Module      : interleaved_stream_splitter
// Description : Splits one valid/ready stream into two lanes in strict
//               alternation, each lane backed by a 2-entry head/skid buffer.
//               Define SPLITTER_SEQ_TAG_EN to add per-lane sequence tags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module interleaved_stream_splitter #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] lane0_data,
    output logic                  lane0_valid,
    input  logic                  lane0_ready,
    output logic [DATA_WIDTH-1:0] lane1_data,
    output logic                  lane1_valid,
    input  logic                  lane1_ready,
    output logic [2:0]            count,
    input  logic                  clear
`ifdef SPLITTER_SEQ_TAG_EN
    ,
    output logic [TAG_WIDTH-1:0]  lane0_tag,
    output logic [TAG_WIDTH-1:0]  lane1_tag
`endif
);

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    logic                       w_flush;
    logic                       w_in_exec;
    logic                       r_in_sel;
    logic [2:0]                 r_count;
    logic [1:0]                 w_push;
    logic [1:0]                 w_pop;
    logic [1:0]                 w_lane_ready;
    logic [1:0][1:0]            w_occ;
    logic [1:0][DATA_WIDTH-1:0] w_head;

    assign w_flush      = rst | clear;
    assign w_lane_ready = {lane1_ready, lane0_ready};

    // Depends only on registered state so there is no ready-to-ready path.
    assign in_ready  = (w_occ[r_in_sel] != c_OCC_FULL);
    assign w_in_exec = in_valid & in_ready;

`ifdef SPLITTER_SEQ_TAG_EN
    logic [TAG_WIDTH-1:0]       r_tag_cnt;
    logic [1:0][TAG_WIDTH-1:0]  w_head_tag;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_tag_cnt <= '0;
        end else if (w_in_exec) begin
            r_tag_cnt <= r_tag_cnt + 1'b1;
        end
    end

    assign lane0_tag = w_head_tag[0];
    assign lane1_tag = w_head_tag[1];
`endif

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_in_sel <= 1'b0;
        end else if (w_in_exec) begin
            r_in_sel <= ~r_in_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_count <= 3'd0;
        end else begin
            r_count <= r_count + 3'(w_in_exec) - 3'(w_pop[0]) - 3'(w_pop[1]);
        end
    end

    assign count = r_count;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [1:0]            r_occ;
            logic [DATA_WIDTH-1:0] r_head;
            logic [DATA_WIDTH-1:0] r_skid;
            logic                  w_to_head;

            assign w_push[gi] = w_in_exec & (r_in_sel == 1'(gi));
            assign w_pop[gi]  = (r_occ != c_OCC_EMPTY) & w_lane_ready[gi];
            assign w_occ[gi]  = r_occ;
            assign w_head[gi] = r_head;

            // A push bypasses skid when the head is free or leaving this cycle.
            assign w_to_head = (r_occ == c_OCC_EMPTY) ||
                               ((r_occ == c_OCC_ONE) && w_pop[gi]);

            always_ff @(posedge clk) begin
                if (w_flush) begin
                    r_occ  <= c_OCC_EMPTY;
                    r_head <= '0;
                    r_skid <= '0;
                end else begin
                    if (w_pop[gi] && (r_occ == c_OCC_FULL)) begin
                        r_head <= r_skid;
                    end
                    if (w_push[gi]) begin
                        if (w_to_head) begin
                            r_head <= in_data;
                        end else begin
                            r_skid <= in_data;
                        end
                    end
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_occ <= r_occ + 2'd1;
                        2'b01:   r_occ <= r_occ - 2'd1;
                        default: r_occ <= r_occ;
                    endcase
                end
            end

`ifdef SPLITTER_SEQ_TAG_EN
            logic [TAG_WIDTH-1:0] r_head_tag;
            logic [TAG_WIDTH-1:0] r_skid_tag;

            assign w_head_tag[gi] = r_head_tag;

            always_ff @(posedge clk) begin
                if (w_flush) begin
                    r_head_tag <= '0;
                    r_skid_tag <= '0;
                end else begin
                    if (w_pop[gi] && (r_occ == c_OCC_FULL)) begin
                        r_head_tag <= r_skid_tag;
                    end
                    if (w_push[gi]) begin
                        if (w_to_head) begin
                            r_head_tag <= r_tag_cnt;
                        end else begin
                            r_skid_tag <= r_tag_cnt;
                        end
                    end
                end
            end
`endif
        end
    endgenerate

    assign lane0_valid = (w_occ[0] != c_OCC_EMPTY);
    assign lane1_valid = (w_occ[1] != c_OCC_EMPTY);
    assign lane0_data  = w_head[0];
    assign lane1_data  = w_head[1];

endmodule

`default_nettype wire

// File: tb/tb_interleaved_stream_splitter.sv
//==============================================================================
// Module      : tb_interleaved_stream_splitter
// Description : Directed scoreboard bench for interleaved_stream_splitter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_interleaved_stream_splitter;

    localparam int DW = 8;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] lane0_data;
    logic          lane0_valid;
    logic          lane0_ready;
    logic [DW-1:0] lane1_data;
    logic          lane1_valid;
    logic          lane1_ready;
    logic [2:0]    count;
`ifdef SPLITTER_SEQ_TAG_EN
    logic [TW-1:0] lane0_tag;
    logic [TW-1:0] lane1_tag;
    logic [TW-1:0] exp_t0[$];
    logic [TW-1:0] exp_t1[$];
`endif

    logic [DW-1:0] exp_d0[$];
    logic [DW-1:0] exp_d1[$];
    logic          tb_sel;
    logic [TW-1:0] tb_tag;
    int            total = 0;
    int            bad   = 0;
    int            w;

    interleaved_stream_splitter #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lane0_data  (lane0_data),
        .lane0_valid (lane0_valid),
        .lane0_ready (lane0_ready),
        .lane1_data  (lane1_data),
        .lane1_valid (lane1_valid),
        .lane1_ready (lane1_ready),
        .count       (count),
        .clear       (clear)
`ifdef SPLITTER_SEQ_TAG_EN
        ,
        .lane0_tag   (lane0_tag),
        .lane1_tag   (lane1_tag)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one word; the expected lane/tag come from the bench's own alternation model.
    task automatic push_word(input logic [DW-1:0] d, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout: word 0x%0h never accepted", d);
            in_valid = 1'b0;
            return;
        end
        if (tb_sel == 1'b0) begin
            exp_d0.push_back(d);
`ifdef SPLITTER_SEQ_TAG_EN
            exp_t0.push_back(tb_tag);
`endif
        end else begin
            exp_d1.push_back(d);
`ifdef SPLITTER_SEQ_TAG_EN
            exp_t1.push_back(tb_tag);
`endif
        end
        tb_sel = ~tb_sel;
        tb_tag = tb_tag + 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every pop on either lane is compared against the scoreboard.
    always @(negedge clk) begin
        if (lane0_valid && lane0_ready) begin
            if (exp_d0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL lane0_unexpected: actual=0x%0h required=none", lane0_data);
            end else begin
                check("lane0_data", lane0_data, exp_d0.pop_front());
`ifdef SPLITTER_SEQ_TAG_EN
                check("lane0_tag", lane0_tag, exp_t0.pop_front());
`endif
            end
        end
        if (lane1_valid && lane1_ready) begin
            if (exp_d1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL lane1_unexpected: actual=0x%0h required=none", lane1_data);
            end else begin
                check("lane1_data", lane1_data, exp_d1.pop_front());
`ifdef SPLITTER_SEQ_TAG_EN
                check("lane1_tag", lane1_tag, exp_t1.pop_front());
`endif
            end
        end
    end

    initial begin
        rst         = 1'b1;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        lane0_ready = 1'b0;
        lane1_ready = 1'b0;
        tb_sel      = 1'b0;
        tb_tag      = '0;
        tick(2);
        rst = 1'b0;
        check("rst_lane0_valid", lane0_valid, 0);
        check("rst_lane1_valid", lane1_valid, 0);
        check("rst_lane0_data", lane0_data, 0);
        check("rst_lane1_data", lane1_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);

        // T1: free-flowing lanes, one-cycle visibility after acceptance
        lane0_ready = 1'b1;
        lane1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_word(8'(8'h10 + i), w);
            check("t1_wait", w, 0);
            check("t1_count", count, 1);
            if (i % 2 == 0) begin
                check("t1_lane0_valid", lane0_valid, 1);
                check("t1_lane0_head", lane0_data, 8'h10 + i);
            end else begin
                check("t1_lane1_valid", lane1_valid, 1);
                check("t1_lane1_head", lane1_data, 8'h10 + i);
            end
        end
        tick(3);
        check("t1_drained", count, 0);

        // T2: lane1 stalled, lane0 keeps draining
        lane1_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_word(8'(8'h20 + i), w);
            check("t2_wait", w, 0);
        end
        in_valid = 1'b1;
        in_data  = 8'h25;
        tick(2);
        check("t2_count", count, 2);
        check("t2_in_ready", in_ready, 0);
        check("t2_lane1_valid", lane1_valid, 1);
        check("t2_lane1_head", lane1_data, 8'h21);
        lane1_ready = 1'b1;
        push_word(8'h25, w);
        check("t2_release_wait", w, 1);
        tick(4);
        check("t2_drained", count, 0);

        // T3/T5: both lanes stalled, changing data must be ignored
        lane0_ready = 1'b0;
        lane1_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(8'(8'h30 + i), w);
            check("t3_wait", w, 0);
        end
        check("t3_count_full", count, 4);
        check("t3_in_ready", in_ready, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'hA0 + i);
            @(negedge clk);
            check("t5_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("t5_count", count, 4);
        check("t5_lane0_head", lane0_data, 8'h30);
        check("t5_lane1_head", lane1_data, 8'h31);
        lane0_ready = 1'b1;
        tick(1);
        lane0_ready = 1'b0;
        check("t3_count_after_pop", count, 3);
        check("t3_in_ready_after_pop", in_ready, 1);
        check("t3_lane0_head", lane0_data, 8'h32);

        // T4: clear with a word offered in the same cycle
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        exp_d0.delete();
        exp_d1.delete();
`ifdef SPLITTER_SEQ_TAG_EN
        exp_t0.delete();
        exp_t1.delete();
`endif
        tb_sel = 1'b0;
        tb_tag = '0;
        tick(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("t4_count", count, 0);
        check("t4_lane0_valid", lane0_valid, 0);
        check("t4_lane1_valid", lane1_valid, 0);
        check("t4_lane0_data", lane0_data, 0);
        check("t4_in_ready", in_ready, 1);

        // T6: post-clear traffic restarts on lane0 with tag 0
        lane0_ready = 1'b1;
        lane1_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_word(8'(8'h50 + i), w);
            check("t6_wait", w, 0);
            if (i == 0) begin
                check("t6_first_lane0_valid", lane0_valid, 1);
                check("t6_first_lane0_head", lane0_data, 8'h50);
`ifdef SPLITTER_SEQ_TAG_EN
                check("t6_first_tag", lane0_tag, 0);
`endif
            end
        end
        tick(4);
        check("t6_drained", count, 0);
        check("end_lane0_queue_empty", exp_d0.size(), 0);
        check("end_lane1_queue_empty", exp_d1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
